// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier final carry-propagate pipeline:
// RISC-V M-extension op encodings, default widths and the stage-1 payload.
package mult_pkg;

    localparam int MULT_DATA_W = 32;
    localparam int MULT_TAG_W  = 5;

    localparam logic [1:0] MUL_OP_MUL    = 2'b00;
    localparam logic [1:0] MUL_OP_MULH   = 2'b01;
    localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
    localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

    // The low word is already resolved; the high halves stay redundant until S2.
    typedef struct packed {
        logic [MULT_DATA_W-1:0] lo;
        logic                   c_lo;
        logic [MULT_DATA_W-1:0] sum_hi;
        logic [MULT_DATA_W-1:0] carry_hi;
        logic [1:0]             op;
        logic [MULT_TAG_W-1:0]  tag;
    } s1_payload_t;

    function automatic logic takes_low_word(input logic [1:0] op);
        return op == MUL_OP_MUL;
    endfunction

endpackage

// File: rtl/mult_cpa_slice.sv
// DATA_W-bit carry-propagate adder slice with carry-in and carry-out.
module mult_cpa_slice #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              cin_i,
    output logic [DATA_W-1:0] sum_o,
    output logic              cout_o
);

    logic [DATA_W:0] full_sum;

    always_comb begin
        full_sum = {1'b0, a_i} + {1'b0, b_i} + {{DATA_W{1'b0}}, cin_i};
        sum_o    = full_sum[DATA_W-1:0];
        cout_o   = full_sum[DATA_W];
    end

endmodule

// File: rtl/mult_final_cpa_pipe.sv
// Resolves the compressor tree's {sum, carry} pair over two register stages
// (low word, then high word) and returns the selected product word with its tag.
module mult_final_cpa_pipe
    import mult_pkg::*;
#(
    parameter int DATA_W = MULT_DATA_W,
    parameter int TAG_W  = MULT_TAG_W
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_flush,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [2*DATA_W-1:0]   i_sum,
    input  logic [2*DATA_W-1:0]   i_carry,
    input  logic [1:0]            i_op,
    input  logic [TAG_W-1:0]      i_tag,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_W-1:0]     o_result,
    output logic [TAG_W-1:0]      o_tag,
    output logic                  o_busy
);

    logic              s1_v_q, s1_v_d;
    logic              s2_v_q, s2_v_d;
    s1_payload_t       s1_q, s1_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic [TAG_W-1:0]  tag_q, tag_d;

    logic              adv2;
    logic              accept;
    logic [DATA_W-1:0] lo_sum;
    logic              c_lo;
    logic [DATA_W-1:0] hi_sum;
    logic              cout_hi_unused;

    // Stage 1 adder: low word, no carry-in.
    mult_cpa_slice #(.DATA_W(DATA_W)) u_cpa_lo (
        .a_i    (i_sum[DATA_W-1:0]),
        .b_i    (i_carry[DATA_W-1:0]),
        .cin_i  (1'b0),
        .sum_o  (lo_sum),
        .cout_o (c_lo)
    );

    // Stage 2 adder: high word; carry out of the top bit is discarded (mod 2^64).
    mult_cpa_slice #(.DATA_W(DATA_W)) u_cpa_hi (
        .a_i    (s1_q.sum_hi),
        .b_i    (s1_q.carry_hi),
        .cin_i  (s1_q.c_lo),
        .sum_o  (hi_sum),
        .cout_o (cout_hi_unused)
    );

    always_comb begin
        adv2    = s1_v_q & (~s2_v_q | i_ready);
        o_ready = ~s1_v_q | adv2;
        accept  = i_valid & o_ready;

        s1_v_d = accept | (s1_v_q & ~adv2);
        s2_v_d = adv2 | (s2_v_q & ~i_ready);
        if (i_flush) begin
            s1_v_d = 1'b0;
            s2_v_d = 1'b0;
        end
    end

    always_comb begin
        s1_d = s1_q;
        if (accept) begin
            s1_d.lo       = lo_sum;
            s1_d.c_lo     = c_lo;
            s1_d.sum_hi   = i_sum[2*DATA_W-1:DATA_W];
            s1_d.carry_hi = i_carry[2*DATA_W-1:DATA_W];
            s1_d.op       = i_op;
            s1_d.tag      = i_tag;
        end
    end

    // The word select happens before the output register so o_result is a flop.
    always_comb begin
        res_d = res_q;
        tag_d = tag_q;
        if (adv2) begin
            res_d = takes_low_word(s1_q.op) ? s1_q.lo : hi_sum;
            tag_d = s1_q.tag;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            s1_v_q <= 1'b0;
            s2_v_q <= 1'b0;
            s1_q   <= '0;
            res_q  <= '0;
            tag_q  <= '0;
        end else begin
            s1_v_q <= s1_v_d;
            s2_v_q <= s2_v_d;
            s1_q   <= s1_d;
            res_q  <= res_d;
            tag_q  <= tag_d;
        end
    end

    assign o_valid  = s2_v_q;
    assign o_result = res_q;
    assign o_tag    = tag_q;
    assign o_busy   = s1_v_q | s2_v_q;

endmodule
